// File: rtl/dadd_out_fifo_if.sv
// Consumer-side handshake bundle for dadd_out_fifo: head entry plus valid/ready.
interface dadd_out_fifo_if #(
  parameter int LOC_AWIDTH = 32,
  parameter int LOC_DWIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [LOC_DWIDTH-1:0] out_data;
  logic [LOC_AWIDTH-1:0] out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/dadd_out_fifo.sv
// Output FIFO for the dadd pipeline: buffers (addr, data) pairs, drops and flags on overflow.
// Optional statistics (fifo_level, drop_cnt) are built when DADD_OUT_FIFO_STAT_EN is defined.
module dadd_out_fifo #(
  parameter int LOC_AWIDTH = 32,
  parameter int LOC_DWIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dadd_out_en,
  input  logic [LOC_DWIDTH-1:0] dadd_out,
  input  logic [LOC_AWIDTH-1:0] dadd_out_addr,
  dadd_out_fifo_if.master       out_if,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  ovf_flag,
  input  logic                  ovf_clr
`ifdef DADD_OUT_FIFO_STAT_EN
  ,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = LOC_AWIDTH + LOC_DWIDTH;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [EW-1:0]         head;

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  assign pop        = out_if.out_valid & out_if.out_ready;
  // Popping frees a slot at the same edge, so a full FIFO can still accept.
  assign push       = dadd_out_en & (~fifo_full | pop);
  assign drop       = dadd_out_en & fifo_full & ~pop;

  assign head             = mem[rd_ptr];
  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : head[LOC_DWIDTH-1:0];
  assign out_if.out_addr  = fifo_empty ? '0 : head[EW-1:LOC_DWIDTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dadd_out_addr, dadd_out};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

`ifdef DADD_OUT_FIFO_STAT_EN
  assign fifo_level = count;

  // A drop in the clearing cycle is the first of the new epoch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dadd_out_fifo.sv
// Self-checking bench for dadd_out_fifo against a queue-based reference model.
module tb_dadd_out_fifo;
  logic        clk;
  logic        rst_n;
  logic        dadd_out_en;
  logic [31:0] dadd_out;
  logic [31:0] dadd_out_addr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ovf_flag;
  logic        ovf_clr;
`ifdef DADD_OUT_FIFO_STAT_EN
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;
`endif

  dadd_out_fifo_if #(.LOC_AWIDTH(32), .LOC_DWIDTH(32)) bus ();

  dadd_out_fifo #(.LOC_AWIDTH(32), .LOC_DWIDTH(32), .DEPTH_LOG2(3)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dadd_out_en   (dadd_out_en),
    .dadd_out      (dadd_out),
    .dadd_out_addr (dadd_out_addr),
    .out_if        (bus),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .ovf_flag      (ovf_flag),
    .ovf_clr       (ovf_clr)
`ifdef DADD_OUT_FIFO_STAT_EN
    ,
    .fifo_level    (fifo_level),
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {addr, data}, sticky flag, drop counter.
  logic [63:0] mq[$];
  logic        m_ovf;
  int          m_drops;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string where);
    logic [63:0] hd;
    hd = (mq.size() == 0) ? 64'd0 : mq[0];
    chk({where, " out_valid"},  {63'd0, bus.out_valid}, {63'd0, mq.size() != 0});
    chk({where, " fifo_empty"}, {63'd0, fifo_empty},    {63'd0, mq.size() == 0});
    chk({where, " fifo_full"},  {63'd0, fifo_full},     {63'd0, mq.size() == 8});
    chk({where, " out_addr"},   {32'd0, bus.out_addr},  {32'd0, hd[63:32]});
    chk({where, " out_data"},   {32'd0, bus.out_data},  {32'd0, hd[31:0]});
    chk({where, " ovf_flag"},   {63'd0, ovf_flag},      {63'd0, m_ovf});
`ifdef DADD_OUT_FIFO_STAT_EN
    chk({where, " fifo_level"}, {60'd0, fifo_level},    64'(mq.size()));
    chk({where, " drop_cnt"},   {48'd0, drop_cnt},      64'(m_drops));
`endif
  endtask

  // Drive one cycle from just after a falling edge, update model at the rising edge, check at the next falling edge.
  task automatic step(input string where, input logic en, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic clr);
    logic do_pop, do_drop;
    dadd_out_en   = en;
    dadd_out_addr = a;
    dadd_out      = d;
    bus.out_ready = rdy;
    ovf_clr       = clr;
    @(posedge clk);
    do_pop  = rdy && (mq.size() != 0);
    do_drop = en && (mq.size() == 8) && !do_pop;
    if (do_pop) void'(mq.pop_front());
    if (en && !do_drop) mq.push_back({a, d});
    if (do_drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drops = do_drop ? 1 : 0;
    else if (do_drop && m_drops < 65535) m_drops++;
    @(negedge clk);
    dadd_out_en = 1'b0;
    ovf_clr     = 1'b0;
    check_all(where);
  endtask

  task automatic fill8(input string where, input int base);
    for (int i = 1; i <= 8; i++) step(where, 1'b1, 32'(base + 4*i), 32'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input string where);
    for (int i = 0; i < 10; i++) step(where, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int pushes;
    int guard;
    n_pass = 0; n_total = 0;
    m_ovf = 1'b0; m_drops = 0;
    rst_n = 1'b0; dadd_out_en = 1'b0; dadd_out = '0; dadd_out_addr = '0;
    ovf_clr = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    step("single_push", 1'b1, 32'h10, 32'h5, 1'b1, 1'b0);
    chk("single_addr", {32'd0, bus.out_addr}, 64'h10);
    chk("single_data", {32'd0, bus.out_data}, 64'h5);
    step("single_pop", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    fill8("fill", 32'h100);
    chk("fill_full", {63'd0, fifo_full}, 64'd1);
    drain("drain");

    fill8("ovf_fill", 32'h200);
    step("ovf_drop", 1'b1, 32'hBAD, 32'h99, 1'b0, 1'b0);
    chk("ovf_set", {63'd0, ovf_flag}, 64'd1);
    drain("ovf_drain");
    step("ovf_clr", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    fill8("full_pp_fill", 32'h300);
    step("full_pp", 1'b1, 32'h3A, 32'hA, 1'b1, 1'b0);
    chk("full_pp_count", {63'd0, fifo_full}, 64'd1);
    drain("full_pp_drain");

    // Occupancy-respecting random traffic with stalls; wraps the pointers.
    pushes = 0; guard = 0;
    while (pushes < 20 && guard < 400) begin
      logic en;
      en = ($urandom_range(0, 1) == 1) && (mq.size() < 8);
      if (en) pushes++;
      step("bp_wrap", en, $urandom, $urandom, $urandom_range(0, 2) == 0, 1'b0);
      guard++;
    end
    chk("bp_wrap_budget", {63'd0, pushes >= 20}, 64'd1);
    drain("bp_drain");

    // Unconstrained random traffic including drops and clears.
    for (int i = 0; i < 120; i++)
      step("random", $urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    drain("random_drain");

    for (int i = 1; i <= 5; i++) step("rst_fill", 1'b1, 32'(i), 32'(16 + i), 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_drops = 0;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step("rst_push", 1'b1, 32'h30, 32'h3, 1'b0, 1'b0);
    chk("rst_only_data", {32'd0, bus.out_data}, 64'h3);
    drain("rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
